// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO router and its LED/GPIO bank.
package mmio_pkg;

  localparam int SLOT_LED = 0;

  localparam int CTRL_BYTE_BIT  = 0;
  localparam int CTRL_WRITE_BIT = 1;

  localparam logic [3:0] ERR_CLEAR_IDX = 4'hF;

  typedef enum logic [1:0] {
    LED_MODE_WRITE = 2'd0,
    LED_MODE_SET   = 2'd1,
    LED_MODE_CLR   = 2'd2,
    LED_MODE_TGL   = 2'd3
  } led_mode_e;

endpackage

// File: rtl/mmio_led_bank.sv
// LED/GPIO bank hosted in slot 0: write/set/clear/toggle of one bit per access,
// plus combinational readback of either one bit or the whole bank.
module mmio_led_bank
  import mmio_pkg::*;
#(
  parameter int LED_COUNT = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [3:0]           idx_i,
  input  led_mode_e            mode_i,
  input  logic                 wbit_i,
  output logic [LED_COUNT-1:0] led_o,
  output logic [15:0]          rdata_o
);

  logic [LED_COUNT-1:0] led_d, led_q;
  logic [LED_COUNT-1:0] sel_mask_s;
  logic [LED_COUNT-1:0] wr_mask_s;
  logic                 in_range_s;

  assign in_range_s = ({1'b0, idx_i} < 5'(LED_COUNT));
  assign sel_mask_s = in_range_s ? (LED_COUNT'(1'b1) << idx_i) : '0;
  assign wr_mask_s  = (we_i && wbit_i) ? sel_mask_s : '0;

  // Next bank state; out-of-range indices leave an all-zero mask and change nothing.
  always_comb begin
    led_d = led_q;
    if (we_i) begin
      case (mode_i)
        LED_MODE_WRITE: led_d = (led_q & ~sel_mask_s) | wr_mask_s;
        LED_MODE_SET:   led_d = led_q | wr_mask_s;
        LED_MODE_CLR:   led_d = led_q & ~wr_mask_s;
        LED_MODE_TGL:   led_d = led_q ^ wr_mask_s;
        default:        led_d = led_q;
      endcase
    end else begin
      led_d = led_q;
    end
  end

  // Bank register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led_o   = led_q;
  assign rdata_o = in_range_s ? {15'h0000, |(led_q & sel_mask_s)} : 16'(led_q);

endmodule

// File: rtl/mmio_router.sv
// Parametrised MMIO router: slot decode, write strobes, pipelined read return,
// LED bank in slot 0, unmapped-access counter. Optional MMIO_ROUTER_ERR_CAPTURE_EN.
module mmio_router
  import mmio_pkg::*;
#(
  parameter int                   NUM_SLOTS         = 8,
  parameter int                   SLOT_SEL_LSB      = 23,
  parameter int                   SLOT_ADDR_W       = 16,
  parameter logic [NUM_SLOTS-1:0] SLOT_PRESENT_MASK = 8'h0F,
  parameter int                   READ_LATENCY      = 2,
  parameter int                   LED_COUNT         = 10
) (
  input  logic                     main_clk,
  input  logic                     main_rst,
  input  logic [31:0]              address_io,
  input  logic [15:0]              data_in_io,
  input  logic [1:0]               control_io,
  output logic [15:0]              data_out_io,
  output logic [NUM_SLOTS-1:0]     slot_write,
  output logic [SLOT_ADDR_W-1:0]   slot_addr,
  output logic [15:0]              slot_wdata,
  output logic                     slot_byte,
  input  logic [16*NUM_SLOTS-1:0]  slot_rdata,
  output logic [LED_COUNT-1:0]     led_out_state,
  output logic [15:0]              unmapped_count
`ifdef MMIO_ROUTER_ERR_CAPTURE_EN
  ,
  output logic [31:0]              err_addr,
  output logic                     err_valid
`endif
);

  localparam int SEL_W = $clog2(NUM_SLOTS);

  typedef struct packed {
    logic             hit;
    logic             byte_mode;
    logic             a0;
    logic [SEL_W-1:0] sel;
    logic [15:0]      led_rd;
  } stage_t;

  logic             hit_s, wr_s, byte_s, present_s, unmapped_s;
  logic [SEL_W-1:0] sel_s;
  logic [15:0]      led_rd_s, nearly_s;
  logic [15:0]      cnt_q;
  stage_t           req_s, fin_s;
  logic             unused_s;

  assign hit_s      = address_io[31];
  assign sel_s      = address_io[SLOT_SEL_LSB +: SEL_W];
  assign present_s  = SLOT_PRESENT_MASK[sel_s];
  assign wr_s       = control_io[CTRL_WRITE_BIT];
  assign byte_s     = control_io[CTRL_BYTE_BIT];
  assign unmapped_s = hit_s & ~present_s;
  assign unused_s   = ^{address_io[30:0], slot_rdata[15:0]};

  assign slot_addr  = address_io[SLOT_ADDR_W-1:0];
  assign slot_byte  = byte_s;
  assign slot_wdata = {byte_s ? data_in_io[7:0] : data_in_io[15:8], data_in_io[7:0]};

  // One-hot write strobe, suppressed for unpopulated slots.
  always_comb begin
    slot_write = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_write[i] = wr_s & hit_s & (sel_s == SEL_W'(i)) & SLOT_PRESENT_MASK[i];
    end
  end

  mmio_led_bank #(.LED_COUNT(LED_COUNT)) u_led_bank (
    .clk_i   (main_clk),
    .rst_i   (main_rst),
    .we_i    (slot_write[SLOT_LED]),
    .idx_i   (address_io[3:0]),
    .mode_i  (led_mode_e'(address_io[5:4])),
    .wbit_i  (data_in_io[0]),
    .led_o   (led_out_state),
    .rdata_o (led_rd_s)
  );

  // LED readback rides the pipeline so it arrives alongside external slot data.
  assign req_s = '{hit: hit_s, byte_mode: byte_s, a0: address_io[0], sel: sel_s, led_rd: led_rd_s};

  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign fin_s = req_s;
    end else begin : g_pipe
      stage_t pipe_q [READ_LATENCY-1];

      // Request pipeline feeding the final (output) stage.
      always_ff @(posedge main_clk) begin
        if (main_rst) begin
          for (int k = 0; k < READ_LATENCY-1; k++) pipe_q[k] <= '0;
        end else begin
          pipe_q[0] <= req_s;
          for (int k = 1; k < READ_LATENCY-1; k++) pipe_q[k] <= pipe_q[k-1];
        end
      end

      assign fin_s = pipe_q[READ_LATENCY-2];
    end
  endgenerate

  // Select the returning slot's data; non-IO and unpopulated accesses read as zero.
  always_comb begin
    nearly_s = 16'h0000;
    if (fin_s.hit && SLOT_PRESENT_MASK[fin_s.sel]) begin
      if (fin_s.sel == SEL_W'(SLOT_LED)) begin
        nearly_s = fin_s.led_rd;
      end else begin
        nearly_s = slot_rdata[{fin_s.sel, 4'h0} +: 16];
      end
    end else begin
      nearly_s = 16'h0000;
    end
  end

  // Registered read return with byte-lane extraction.
  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      data_out_io <= 16'h0000;
    end else if (fin_s.byte_mode) begin
      data_out_io <= {8'h00, fin_s.a0 ? nearly_s[15:8] : nearly_s[7:0]};
    end else begin
      data_out_io <= nearly_s;
    end
  end

  // Saturating count of IO accesses to unpopulated slots.
  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      cnt_q <= 16'h0000;
    end else if (unmapped_s && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'h0001;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign unmapped_count = cnt_q;

`ifdef MMIO_ROUTER_ERR_CAPTURE_EN
  logic        err_clr_s;
  logic        err_valid_q;
  logic [31:0] err_addr_q;

  assign err_clr_s = slot_write[SLOT_LED] && (address_io[5:4] == 2'(LED_MODE_WRITE)) &&
                     (address_io[3:0] == ERR_CLEAR_IDX) && data_in_io[0];

  // First unmapped address is held; a fresh error wins over a clear in the same cycle.
  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= 32'h0000_0000;
    end else if (unmapped_s && (!err_valid_q || err_clr_s)) begin
      err_valid_q <= 1'b1;
      err_addr_q  <= address_io;
    end else if (err_clr_s) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= 32'h0000_0000;
    end else begin
      err_valid_q <= err_valid_q;
      err_addr_q  <= err_addr_q;
    end
  end

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
`endif

endmodule
